// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline stages and hazard_ctrl.
// The master side is the pipeline, which supplies hazard inputs; the slave side is the controller, which returns the strobes.
interface hazard_ctrl_if;
  logic [4:0] rs1_addr_IF;
  logic [4:0] rs2_addr_IF;
  logic       rs1_access_IF;
  logic       rs2_access_IF;
  logic [4:0] rd_addr_ID;
  logic       rd_access_ID;
  logic       dmem_access_ID;
  logic       sel_MUL_ID;
  logic       sel_DIV_ID;
  logic       jump_taken;
  logic       dmem_access_MEM;
  logic       dmem_ready;
  logic       stall_IF;
  logic       clear_IF;
  logic       stall_ID;
  logic       clear_ID;
  logic       stall_EX;
  logic       clear_EX;
  logic       wb_inhibit;
  logic       mul_start;
  logic       div_start;
  logic       busy;

  modport master (
    output rs1_addr_IF, rs2_addr_IF, rs1_access_IF, rs2_access_IF,
    output rd_addr_ID, rd_access_ID, dmem_access_ID, sel_MUL_ID, sel_DIV_ID,
    output jump_taken, dmem_access_MEM, dmem_ready,
    input  stall_IF, clear_IF, stall_ID, clear_ID, stall_EX, clear_EX,
    input  wb_inhibit, mul_start, div_start, busy
  );

  modport slave (
    input  rs1_addr_IF, rs2_addr_IF, rs1_access_IF, rs2_access_IF,
    input  rd_addr_ID, rd_access_ID, dmem_access_ID, sel_MUL_ID, sel_DIV_ID,
    input  jump_taken, dmem_access_MEM, dmem_ready,
    output stall_IF, clear_IF, stall_ID, clear_ID, stall_EX, clear_EX,
    output wb_inhibit, mul_start, div_start, busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use bubbles, jump flushes,
// MUL/DIV occupancy of EX and data-memory wait states.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MUL_WAIT = 2'd2;
  localparam logic [1:0] ST_DIV_WAIT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stall_if_s, clear_if_s, stall_id_s, clear_id_s, stall_ex_s, clear_ex_s;
  logic wb_inhibit_s, mul_start_s, div_start_s;
  logic mem_wait_s, load_use_s;

  // Destination x0 is never a real producer, so it never triggers a bubble.
  function automatic logic load_use_f(
    input logic [4:0] rs1, input logic rs1_acc,
    input logic [4:0] rs2, input logic rs2_acc,
    input logic [4:0] rd,  input logic rd_acc, input logic is_mem
  );
    return rd_acc && is_mem && (rd != 5'd0) &&
           ((rs1_acc && (rs1 == rd)) || (rs2_acc && (rs2 == rd)));
  endfunction

  assign mem_wait_s = hz.dmem_access_MEM && !hz.dmem_ready;
  assign load_use_s = load_use_f(hz.rs1_addr_IF, hz.rs1_access_IF,
                                 hz.rs2_addr_IF, hz.rs2_access_IF,
                                 hz.rd_addr_ID, hz.rd_access_ID, hz.dmem_access_ID);

  // Next-state and strobe decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_if_s   = 1'b0;
    clear_if_s   = 1'b0;
    stall_id_s   = 1'b0;
    clear_id_s   = 1'b0;
    stall_ex_s   = 1'b0;
    clear_ex_s   = 1'b0;
    wb_inhibit_s = 1'b0;
    mul_start_s  = 1'b0;
    div_start_s  = 1'b0;
    case (state_q)
      // The MEM_WAIT release cycle re-runs the idle decode so a held jump or
      // MUL/DIV in EX is acted on without losing a cycle.
      ST_IDLE, ST_MEM_WAIT: begin
        if (mem_wait_s) begin
          stall_if_s   = 1'b1;
          stall_id_s   = 1'b1;
          stall_ex_s   = 1'b1;
          wb_inhibit_s = 1'b1;
          state_d      = ST_MEM_WAIT;
        end else if (hz.jump_taken) begin
          clear_if_s = 1'b1;
          clear_id_s = 1'b1;
          state_d    = ST_IDLE;
        end else if (hz.sel_DIV_ID) begin
          div_start_s = 1'b1;
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          clear_ex_s  = 1'b1;
          cnt_d       = DIV_LOAD;
          state_d     = ST_DIV_WAIT;
        end else if (hz.sel_MUL_ID) begin
          mul_start_s = 1'b1;
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          clear_ex_s  = 1'b1;
          cnt_d       = MUL_LOAD;
          state_d     = ST_MUL_WAIT;
        end else if (load_use_s) begin
          stall_if_s = 1'b1;
          clear_id_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_WAIT, ST_DIV_WAIT: begin
        if (cnt_q != '0) begin
          stall_if_s = 1'b1;
          stall_id_s = 1'b1;
          clear_ex_s = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.stall_IF   = !reset && stall_if_s;
  assign hz.clear_IF   = !reset && clear_if_s;
  assign hz.stall_ID   = !reset && stall_id_s;
  assign hz.clear_ID   = !reset && clear_id_s;
  assign hz.stall_EX   = !reset && stall_ex_s;
  assign hz.clear_EX   = !reset && clear_ex_s;
  assign hz.wb_inhibit = !reset && wb_inhibit_s;
  assign hz.mul_start  = !reset && mul_start_s;
  assign hz.div_start  = !reset && div_start_s;
  assign hz.busy       = !reset && (state_q != ST_IDLE);
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It generates the stall/clear strobes for the IF/ID, ID/EX and EX/MEM pipeline registers, handling four cases: load-use hazards, taken-jump flushes, multi-cycle MUL/DIV occupancy of EX, and data-memory wait states. It sits beside the ID stage and consumes the instruction decoder's register-access outputs plus the ID/EX register contents.

## Interface
- MUL_CYCLES, 2: cycles the multiplier needs from mul_start to valid result (≥1).
- DIV_CYCLES, 32: cycles the divider needs from div_start to valid result (≥1).

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rs1_addr_IF / rs2_addr_IF  in  5  source registers of the instruction in IF/ID (decoder output)
- rs1_access_IF / rs2_access_IF  in  1  source actually read
- rd_addr_ID  in  5  destination of the instruction in EX (ID/EX register)
- rd_access_ID, dmem_access_ID, sel_MUL_ID, sel_DIV_ID  in  1  ID/EX control fields
- jump_taken  in  1  EX resolved a taken jump/branch this cycle
- dmem_access_MEM  in  1  MEM stage holds a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- stall_IF  out  1  hold PC and IF/ID register
- clear_IF  out  1  flush IF/ID register to bubble
- stall_ID  out  1  hold ID/EX register (drives ID stage `stall`)
- clear_ID  out  1  bubble into ID/EX (drives ID stage `clear`; overrides stall there)
- stall_EX  out  1  hold EX/MEM register
- clear_EX  out  1  bubble into EX/MEM
- wb_inhibit  out  1  suppress register-file write from MEM
- mul_start / div_start  out  1  one-cycle start pulse to the multiplier/divider
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, MEM_WAIT, MUL_WAIT, DIV_WAIT. A down-counter cnt, sized to max(MUL_CYCLES,DIV_CYCLES), supports the MUL/DIV waits.
- Priority in IDLE, highest first: memory wait, jump flush, MUL/DIV start, load-use.
- Memory wait (dmem_access_MEM && !dmem_ready):
  - Assert stall_IF, stall_ID, stall_EX and wb_inhibit.
  - Next state MEM_WAIT. MEM_WAIT drives the same outputs and returns to IDLE in the cycle after dmem_ready=1.
  - In the dmem_ready cycle, no stall is asserted.
- Jump (jump_taken, no memory wait): clear_IF=1 and clear_ID=1 for one cycle. A jump pending during MEM_WAIT is held (ID/EX frozen) and applied in the release cycle.
- MUL/DIV start (sel_DIV_ID or sel_MUL_ID, no memory wait):
  - Pulse div_start/mul_start.
  - Assert stall_IF, stall_ID and clear_EX.
  - Load cnt with CYCLES−1 and go to DIV_WAIT/MUL_WAIT.
- DIV_WAIT/MUL_WAIT:
  - stall_IF=stall_ID=1 and clear_EX=1 while cnt≠0; cnt decrements each cycle.
  - When cnt=0: all strobes low (EX/MEM captures the result, ID/EX advances), next state IDLE.
  - A back-to-back DIV restarts from IDLE in the following cycle.
- Load-use (rd_access_ID && dmem_access_ID && rd_addr_ID≠0 && (rs1_access_IF && rs1_addr_IF==rd_addr_ID || rs2_access_IF && rs2_addr_IF==rd_addr_ID)): stall_IF=1, clear_ID=1 for one cycle. A match on x0 never stalls.
- stall_ID and clear_ID are never asserted together.
- The same EX instruction never produces a second start pulse.

## Timing
- Reset: state IDLE, cnt=0. While reset is high, every output is forced to 0. Reset mid-wait aborts the sequence; no start pulse is issued in the first cycle after reset release unless sel_*_ID=1 then.
- All outputs are combinational from state, cnt and inputs, valid in the same cycle. State and cnt update on posedge clk.
- DIV occupancy of EX is DIV_CYCLES+1 cycles, from the div_start cycle through the cnt=0 cycle. MUL is analogous.
- Load-use costs exactly 1 bubble. A jump costs 2 flushed slots.
- MEM_WAIT cannot coincide with MUL/DIV_WAIT: MUL/DIV starts only when MEM is not waiting, and EX/MEM carries bubbles thereafter.

## Test plan
- Load-use: EX holds `lw x5`, IF holds `add x6,x5,x1` → one cycle with stall_IF=1, clear_ID=1; next cycle no strobes. Repeat with rd=x0 → no strobes.
- Jump: jump_taken=1 for one cycle → clear_IF=clear_ID=1 in that cycle only; with a simultaneous load-use match, stall_IF stays 0.
- DIV, DIV_CYCLES=4: sel_DIV_ID=1 at cycle T → div_start at T only; stall_IF/stall_ID/clear_EX high T..T+3; all low at T+4; busy high T+1..T+4.
- Memory wait with pending jump: dmem_access_MEM=1, dmem_ready=0 for 3 cycles, jump_taken=1 → stalls plus wb_inhibit for those 3 cycles, then clear_IF/clear_ID in the dmem_ready cycle.
- Reset mid-DIV: assert reset at cnt=2 → outputs 0 immediately, state IDLE; after release with sel_DIV_ID=0 → no strobes.
- Back-to-back DIV then MUL (MUL_CYCLES=2): each issues exactly one start pulse, with no gap cycle between the DIV release and mul_start.
